mdu_unit: RTL and testbench
===========================

MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO register width in bits.
REQ-002 Parameter MULT_CYCLES, default 5: busy duration of multiply ops, legal 1..15.
REQ-003 Parameter DIV_CYCLES, default 10: busy duration of divide ops, legal 1..15.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, asynchronous and active-low (0 = in reset).
REQ-006 start  input  1  one-cycle request to issue op with operands a and b.
REQ-007 op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-008 a  input  WIDTH  rs operand.
REQ-009 b  input  WIDTH  rt operand.
REQ-010 flush  input  1  cancel of an in-flight multiply/divide.
REQ-011 busy  output  1  high while a multiply/divide is in flight.
REQ-012 hi  output  WIDTH  architectural HI register.
REQ-013 lo  output  WIDTH  architectural LO register.

Function
REQ-014 States SHALL be IDLE and RUN; no other states.
REQ-015 In IDLE, start with op MULT/MULTU/DIV/DIVU SHALL latch the full result into shadow registers, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-016 busy SHALL be 1 from the cycle after accepting start until the cycle HI/LO commit, inclusive: exactly MULT_CYCLES or DIV_CYCLES cycles.
REQ-017 In RUN the counter SHALL decrement each cycle; at count 1 the next edge SHALL commit the shadow values to HI/LO, clear busy and return to IDLE.
REQ-018 MULT: {hi,lo} = signed a*b, 2*WIDTH bits. MULTU: the same product, unsigned.
REQ-019 DIV: lo = signed quotient truncated toward zero, hi = remainder with the sign of a. DIVU: unsigned quotient and remainder.
REQ-020 Divide with b == 0 SHALL run the full DIV_CYCLES busy period and leave HI/LO unchanged.
REQ-021 Signed overflow (most negative value / -1) SHALL give lo = most negative value, hi = 0.
REQ-022 MTHI/MTLO with start in IDLE SHALL write a to hi/lo on the next edge, with no busy and no counter change.
REQ-023 Any start while in RUN, including MTHI/MTLO, SHALL be ignored; the issuing pipeline is responsible for stalling on busy.
REQ-024 flush in RUN SHALL return to IDLE on the next edge, clear busy and leave HI/LO unchanged; flush in IDLE has no effect.
REQ-025 If flush and start are both high in IDLE, start SHALL be accepted.
REQ-026 If flush is high on the commit cycle (count 1), flush SHALL win: no commit.
REQ-027 An undefined op with start SHALL be ignored.
REQ-028 hi and lo SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-029 When reset is 0, the block SHALL force asynchronously: state IDLE, counter 0, busy 0, hi 0, lo 0, shadow registers 0.
REQ-030 Reset asserted mid-RUN SHALL abort the operation; no commit occurs after release.
REQ-031 The first start SHALL be accepted on the first rising edge at which reset is 1.

Structure
REQ-032 The op encodings (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5), the state encoding and the default latencies SHALL live in a shared package, mdu_pkg, used by the controllers.
REQ-033 Result computation SHALL sit in one combinational sub-module, mdu_calc (inputs op, a, b; outputs 2*WIDTH result and a div-by-zero flag). Sequencing SHALL stay in mdu_unit.

Verification
REQ-034 Scenario: MULT a=0xFFFFFFFE (-2), b=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 Scenario: DIVU a=7, b=2 -> busy high for 10 cycles, then hi=1, lo=3. DIV a=-7, b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD.
REQ-036 Scenario: DIV a=5, b=0 with prior hi=0x11, lo=0x22 -> busy for 10 cycles, then hi=0x11, lo=0x22.
REQ-037 Scenario: MULTU 3*4 followed by MTLO a=0x55 on the next cycle while busy -> MTLO ignored; final hi=0, lo=12.
REQ-038 Scenario: MULT 2*2 with flush at busy cycle 3 -> busy drops on the next edge; HI/LO keep their old values. Repeat with flush on the commit cycle -> no commit.
REQ-039 Scenario: reset pulsed low mid-DIV -> busy, hi and lo all 0 immediately; no later commit; MTHI a=0x9 after release -> hi=0x9 on the next edge.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, controller states
// and default latencies.
package mdu_pkg;

   localparam int DEF_WIDTH       = 32;
   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;
   localparam int CNT_W           = 4;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   function automatic logic is_mul_op(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the pipeline and the multiply/divide unit.
interface mdu_if #(parameter int WIDTH = 32);
   // start is a single-cycle request, honoured only while busy is low; the
   // issuer must hold off further mul/div/mt requests until busy drops.
   // hi/lo always reflect the architectural registers.
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, flush, input busy, hi, lo);
   modport slave  (input start, op, a, b, flush, output busy, hi, lo);
endinterface

// File: rtl/mdu_calc.sv
// Combinational result generator: {hi,lo} for multiplies, {remainder,quotient}
// for divides, plus a divide-by-zero flag.
module mdu_calc
   import mdu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] result,
   output logic               div_zero
);

   logic signed [2*WIDTH-1:0] sa, sb, prod_s;
   logic [2*WIDTH-1:0]        ua, ub, prod_u;
   logic                      a_neg, b_neg, b_zero;
   logic [WIDTH-1:0]          abs_a, abs_b, div_u, div_s;
   logic [WIDTH-1:0]          q_u, r_u, q_mag, r_mag, q_s, r_s;

   assign sa     = {{WIDTH{a[WIDTH-1]}}, a};
   assign sb     = {{WIDTH{b[WIDTH-1]}}, b};
   assign prod_s = sa * sb;
   assign ua     = {{WIDTH{1'b0}}, a};
   assign ub     = {{WIDTH{1'b0}}, b};
   assign prod_u = ua * ub;

   // Signed divide works on magnitudes; MIN / -1 falls out as MIN with rem 0.
   assign a_neg  = a[WIDTH-1];
   assign b_neg  = b[WIDTH-1];
   assign b_zero = (b == '0);
   assign abs_a  = a_neg ? (~a + 1'b1) : a;
   assign abs_b  = b_neg ? (~b + 1'b1) : b;
   // Substitute a divisor of 1 on zero so the datapath never produces X.
   assign div_u  = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
   assign div_s  = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
   assign q_u    = a / div_u;
   assign r_u    = a % div_u;
   assign q_mag  = abs_a / div_s;
   assign r_mag  = abs_a % div_s;
   assign q_s    = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
   assign r_s    = a_neg ? (~r_mag + 1'b1) : r_mag;

   always_comb begin
      result   = '0;
      div_zero = 1'b0;
      case (op)
         OP_MULT:  result = prod_s;
         OP_MULTU: result = prod_u;
         OP_DIV: begin
            result   = {r_s, q_s};
            div_zero = b_zero;
         end
         OP_DIVU: begin
            result   = {r_u, q_u};
            div_zero = b_zero;
         end
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/mdu_unit.sv
// HI/LO multiply/divide unit: computes at issue, holds the result in shadow
// registers for a fixed busy period, then commits unless flushed.
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   mdu_if.slave       bus,
   output mdu_state_e state_dbg
);

   mdu_state_e         state, state_nxt;
   logic [CNT_W-1:0]   count, count_nxt;
   logic [WIDTH-1:0]   hi_q, hi_nxt, lo_q, lo_nxt;
   logic [WIDTH-1:0]   sh_hi, sh_hi_nxt, sh_lo, sh_lo_nxt;
   logic               commit_en, commit_en_nxt;
   logic [2*WIDTH-1:0] calc_result;
   logic               calc_div_zero;

   mdu_calc #(.WIDTH(WIDTH)) u_calc (
      .op       (bus.op),
      .a        (bus.a),
      .b        (bus.b),
      .result   (calc_result),
      .div_zero (calc_div_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         count     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         sh_hi     <= '0;
         sh_lo     <= '0;
         commit_en <= 1'b0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         hi_q      <= hi_nxt;
         lo_q      <= lo_nxt;
         sh_hi     <= sh_hi_nxt;
         sh_lo     <= sh_lo_nxt;
         commit_en <= commit_en_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      count_nxt     = count;
      hi_nxt        = hi_q;
      lo_nxt        = lo_q;
      sh_hi_nxt     = sh_hi;
      sh_lo_nxt     = sh_lo;
      commit_en_nxt = commit_en;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               if (is_mul_op(bus.op) || is_div_op(bus.op)) begin
                  sh_hi_nxt     = calc_result[2*WIDTH-1:WIDTH];
                  sh_lo_nxt     = calc_result[WIDTH-1:0];
                  commit_en_nxt = !calc_div_zero;
                  count_nxt     = is_mul_op(bus.op) ? CNT_W'(MULT_CYCLES)
                                                    : CNT_W'(DIV_CYCLES);
                  state_nxt     = ST_RUN;
               end else if (bus.op == OP_MTHI) begin
                  hi_nxt = bus.a;
               end else if (bus.op == OP_MTLO) begin
                  lo_nxt = bus.a;
               end
            end
         end
         ST_RUN: begin
            // Flush outranks the commit even on the final count.
            if (bus.flush) begin
               state_nxt = ST_IDLE;
               count_nxt = '0;
            end else if (count == CNT_W'(1)) begin
               if (commit_en) begin
                  hi_nxt = sh_hi;
                  lo_nxt = sh_lo;
               end
               state_nxt = ST_IDLE;
               count_nxt = '0;
            end else begin
               count_nxt = count - 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bus.busy  = (state == ST_RUN);
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: scoreboard of expected {hi,lo} per issued op.
module tb_mdu_unit;
   import mdu_pkg::*;

   localparam int W  = 32;
   localparam int MC = 5;
   localparam int DC = 10;

   logic       clk;
   logic       reset;
   mdu_state_e state_dbg;

   mdu_if #(.WIDTH(W)) bus ();

   mdu_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_q[$];
   logic [W-1:0] model_hi = '0;
   logic [W-1:0] model_lo = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: updates model_hi/lo, pushes expected state, returns busy length.
   task automatic model_push(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                             output int lat);
      longint      q, r;
      logic [63:0] p, ux, uy;
      lat = 0;
      case (o)
         3'd0: begin
            p = 64'(longint'($signed(x)) * longint'($signed(y)));
            {model_hi, model_lo} = p;
            lat = MC;
         end
         3'd1: begin
            ux = {32'b0, x};
            uy = {32'b0, y};
            p  = ux * uy;
            {model_hi, model_lo} = p;
            lat = MC;
         end
         3'd2: begin
            if (y != 0) begin
               q = longint'($signed(x)) / longint'($signed(y));
               r = longint'($signed(x)) % longint'($signed(y));
               model_lo = q[31:0];
               model_hi = r[31:0];
            end
            lat = DC;
         end
         3'd3: begin
            if (y != 0) begin
               model_lo = x / y;
               model_hi = x % y;
            end
            lat = DC;
         end
         3'd4: model_hi = x;
         3'd5: model_lo = x;
         default: ;
      endcase
      exp_q.push_back({model_hi, model_lo});
   endtask

   // Called on a falling edge; the request is seen by the next rising edge.
   task automatic drive_start(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      int          cnt;
      logic [63:0] e;
      cnt = 0;
      while (bus.busy && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      check_eq({tag, "_lat"}, 64'(cnt), 64'(exp_lat));
      if (exp_q.size() == 0) begin
         check_eq({tag, "_q_empty"}, 64'd1, 64'd0);
      end else begin
         e = exp_q.pop_front();
         check_eq({tag, "_hilo"}, {bus.hi, bus.lo}, e);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
      int lat;
      model_push(o, x, y, lat);
      drive_start(o, x, y);
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(tag, lat);
   endtask

   initial begin
      int lat;
      bus.start = 1'b0;
      bus.op    = '0;
      bus.a     = '0;
      bus.b     = '0;
      bus.flush = 1'b0;
      reset     = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 64'(bus.busy), 64'd0);
      check_eq("rst_hilo", {bus.hi, bus.lo}, 64'd0);
      check_eq("rst_state", 64'(state_dbg), 64'(ST_IDLE));

      // First op presented together with reset release.
      reset = 1'b1;
      run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3);
      run_op("divu", OP_DIVU, 32'd7, 32'd2);
      run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);

      run_op("mthi", OP_MTHI, 32'h11, 32'd0);
      run_op("mtlo", OP_MTLO, 32'h22, 32'd0);
      run_op("div_zero", OP_DIV, 32'd5, 32'd0);
      run_op("divu_zero", OP_DIVU, 32'd9, 32'd0);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("bad_op", 3'd6, 32'hDEAD, 32'hBEEF);
      run_op("bad_op7", 3'd7, 32'hDEAD, 32'hBEEF);

      // MTLO while busy is ignored.
      model_push(OP_MULTU, 32'd3, 32'd4, lat);
      drive_start(OP_MULTU, 32'd3, 32'd4);
      @(negedge clk);
      check_eq("mtlo_busy_b", 64'(bus.busy), 64'd1);
      drive_start(OP_MTLO, 32'h55, 32'd0);
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("mtlo_busy", lat - 1);

      // Flush at busy cycle 3.
      drive_start(OP_MULT, 32'd2, 32'd2);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("fl3_busy", 64'(bus.busy), 64'd1);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check_eq("fl3_drop", 64'(bus.busy), 64'd0);
      exp_q.push_back({model_hi, model_lo});
      wait_done("fl3", 0);

      // Flush on the commit cycle.
      drive_start(OP_MULT, 32'd2, 32'd2);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (MC - 1) @(negedge clk);
      check_eq("flc_busy", 64'(bus.busy), 64'd1);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check_eq("flc_drop", 64'(bus.busy), 64'd0);
      repeat (3) @(negedge clk);
      exp_q.push_back({model_hi, model_lo});
      wait_done("flc", 0);

      // Flush in idle alone does nothing; flush with start accepts the start.
      bus.flush = 1'b1;
      @(negedge clk);
      check_eq("fl_idle_busy", 64'(bus.busy), 64'd0);
      model_push(OP_MULTU, 32'd5, 32'd6, lat);
      drive_start(OP_MULTU, 32'd5, 32'd6);
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = 1'b0;
      wait_done("fl_start", lat);

      // Random mix.
      for (int i = 0; i < 10; i++) begin
         logic [2:0]   o;
         logic [W-1:0] x, y;
         o = 3'($urandom_range(0, 5));
         x = $urandom;
         y = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
         if ($urandom_range(0, 1) == 1) y = y >> $urandom_range(0, 28);
         run_op("rand", o, x, y);
      end

      // Reset mid-divide.
      drive_start(OP_DIV, 32'd100, 32'd7);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_eq("rmid_busy", 64'(bus.busy), 64'd0);
      check_eq("rmid_hilo", {bus.hi, bus.lo}, 64'd0);
      model_hi = '0;
      model_lo = '0;
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      check_eq("rmid_after_busy", 64'(bus.busy), 64'd0);
      check_eq("rmid_after_hilo", {bus.hi, bus.lo}, 64'd0);
      run_op("mthi_post", OP_MTHI, 32'h9, 32'd0);

      check_eq("q_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
